// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the unified IF/DM memory arbiter of the MIPS core.
package mips_mem_pkg;

   localparam int ADDR_W_DEF     = 10;
   localparam int DATA_W_DEF     = 32;
   localparam int STREAK_MAX_DEF = 4;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   typedef enum logic [1:0] {
      RUN    = ST_RUN,
      DRAIN  = ST_DRAIN,
      HALTED = ST_HALTED
   } arb_state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      IF   = 2'd1,
      DM   = 2'd2
   } owner_t;

   // Any set bit above the RAM index field puts the word outside the array.
   function automatic logic addr_oob(input logic [31:0] addr, input int aw);
      return (addr >> aw) != 32'd0;
   endfunction

endpackage

// File: rtl/mips_arb_priority.sv
// Grant select between fetch and data requesters with an anti-starvation streak counter.
module mips_arb_priority #(
   parameter int STREAK_MAX = 4
) (
   input  logic clk1,
   input  logic rst_n,
   input  logic if_req,
   input  logic dm_req,
   input  logic if_allow,
   input  logic dm_allow,
   output logic if_gnt,
   output logic dm_gnt
);

   logic [3:0] streak;
   logic       streak_full;

   assign streak_full = (streak == 4'(STREAK_MAX));

   // DM normally wins; once IF has watched STREAK_MAX DM grants in a row it gets the slot.
   always_comb begin
      if_gnt = if_allow && if_req && (!dm_req || streak_full);
      dm_gnt = dm_allow && dm_req && !if_gnt;
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         streak <= 4'd0;
      end else if (!if_req || if_gnt) begin
         streak <= 4'd0;
      end else if (dm_gnt && !streak_full) begin
         streak <= streak + 4'd1;
      end
   end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one synchronous RAM port between instruction fetch and load/store, routes
// read returns to their owner and drains cleanly to a stop after HLT.
module mips_mem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STREAK_MAX = STREAK_MAX_DEF
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [31:0]       dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   input  logic              halt,
   output logic              halted,
   output logic              err_oob,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output arb_state_t        dbg_state
);

   // Handshake: a requester holds req and its payload stable until it sees gnt in the
   // same cycle; a granted read returns exactly one cycle later as a one-cycle rvalid.

   arb_state_t        state_q, state_d;
   owner_t            owner_q, owner_d;
   logic              ret_oob_q;
   logic              if_allow, dm_allow;
   logic              if_oob, dm_oob, grant_oob;
   logic [DATA_W-1:0] ret_data;
   logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

   // Gating by rst_n keeps grants low for the whole time reset is asserted.
   assign if_allow = rst_n && (state_q == RUN) && !halt;
   assign dm_allow = rst_n && (state_q != HALTED);

   mips_arb_priority #(.STREAK_MAX(STREAK_MAX)) u_prio (
      .clk1     (clk1),
      .rst_n    (rst_n),
      .if_req   (if_req),
      .dm_req   (dm_req),
      .if_allow (if_allow),
      .dm_allow (dm_allow),
      .if_gnt   (if_gnt),
      .dm_gnt   (dm_gnt)
   );

   assign if_oob    = addr_oob(if_addr, ADDR_W);
   assign dm_oob    = addr_oob(dm_addr, ADDR_W);
   assign grant_oob = (if_gnt && if_oob) || (dm_gnt && dm_oob);

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (if_gnt) begin
         mem_en   = !if_oob;
         mem_addr = if_addr[ADDR_W-1:0];
      end else if (dm_gnt) begin
         mem_en    = !dm_oob;
         mem_we    = dm_we && !dm_oob;
         mem_addr  = dm_addr[ADDR_W-1:0];
         mem_wdata = dm_wdata;
      end
   end

   always_comb begin
      owner_d = NONE;
      if (if_gnt) begin
         owner_d = IF;
      end else if (dm_gnt && !dm_we) begin
         owner_d = DM;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (halt) state_d = DRAIN;
         DRAIN:   if (!dm_req && (owner_q == NONE)) state_d = HALTED;
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   assign ret_data  = ret_oob_q ? '0 : mem_rdata;
   assign if_rvalid = (owner_q == IF);
   assign dm_rvalid = (owner_q == DM);
   // During the pulse the RAM word passes straight through; afterwards the captured copy holds.
   assign if_rdata  = if_rvalid ? ret_data : if_rdata_q;
   assign dm_rdata  = dm_rvalid ? ret_data : dm_rdata_q;
   assign halted    = (state_q == HALTED);
   assign dbg_state = state_q;

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         owner_q    <= NONE;
         ret_oob_q  <= 1'b0;
         err_oob    <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ret_oob_q <= grant_oob;
         err_oob   <= err_oob || grant_oob;
         if (if_rvalid) if_rdata_q <= ret_data;
         if (dm_rvalid) dm_rdata_q <= ret_data;
      end
   end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a behavioural RAM and a return scoreboard.
module tb_mips_mem_arbiter;
   import mips_mem_pkg::*;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk1 = 1'b0;
   logic          rst_n;
   logic          if_req, if_gnt, if_rvalid;
   logic [31:0]   if_addr;
   logic [DW-1:0] if_rdata;
   logic          dm_req, dm_we, dm_gnt, dm_rvalid;
   logic [31:0]   dm_addr;
   logic [DW-1:0] dm_wdata, dm_rdata;
   logic          halt, halted, err_oob;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   arb_state_t    dbg_state;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [DW-1:0] if_exp_q[$];
   int            if_due_q[$];
   logic [DW-1:0] dm_exp_q[$];
   int            dm_due_q[$];

   logic [DW-1:0] ram [0:(1<<AW)-1];

   mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STREAK_MAX(4)) dut (
      .clk1(clk1), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .halt(halt), .halted(halted), .err_oob(err_oob),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk1 = ~clk1;

   always @(posedge clk1) cyc <= cyc + 1;

   function automatic logic [DW-1:0] init_word(input int i);
      if (i == 0) return 32'h2801_0064;
      return 32'h2001_0000 + 32'(i);
   endfunction

   // Synchronous RAM: read data appears the cycle after mem_en & !mem_we.
   initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = (i < 16) ? init_word(i) : '0;
      forever begin
         @(posedge clk1);
         if (mem_en) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            else        mem_rdata <= ram[mem_addr];
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- check helpers ----------------
   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk1);
   endtask

   task automatic push_if(input logic [DW-1:0] d);
      if_exp_q.push_back(d);
      if_due_q.push_back(cyc + 1);
   endtask

   task automatic push_dm(input logic [DW-1:0] d);
      dm_exp_q.push_back(d);
      dm_due_q.push_back(cyc + 1);
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk1) begin
      if (if_due_q.size() > 0 && if_due_q[0] == cyc) begin
         chk1("if_rvalid", if_rvalid, 1'b1);
         chkw("if_rdata", if_rdata, if_exp_q[0]);
         void'(if_exp_q.pop_front());
         void'(if_due_q.pop_front());
      end else begin
         chk1("if_rvalid_idle", if_rvalid, 1'b0);
      end
      if (dm_due_q.size() > 0 && dm_due_q[0] == cyc) begin
         chk1("dm_rvalid", dm_rvalid, 1'b1);
         chkw("dm_rdata", dm_rdata, dm_exp_q[0]);
         void'(dm_exp_q.pop_front());
         void'(dm_due_q.pop_front());
      end else begin
         chk1("dm_rvalid_idle", dm_rvalid, 1'b0);
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic exp_if;

      rst_n = 1'b0; halt = 1'b0;
      if_req = 1'b1; if_addr = 32'd3;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'd7; dm_wdata = 32'hDEAD_BEEF;

      // Reset values while both requesters are asserting
      at_neg();
      chk1("rst_if_gnt", if_gnt, 1'b0);
      chk1("rst_dm_gnt", dm_gnt, 1'b0);
      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chkw("rst_mem_addr", 32'(mem_addr), 32'd0);
      chkw("rst_mem_wdata", mem_wdata, 32'd0);
      chkw("rst_if_rdata", if_rdata, 32'd0);
      chkw("rst_dm_rdata", dm_rdata, 32'd0);
      chk1("rst_halted", halted, 1'b0);
      chk1("rst_err_oob", err_oob, 1'b0);
      chkw("rst_state", 32'(dbg_state), 32'(RUN));
      tick();
      rst_n = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      tick();

      // Fetch only, back-to-back
      for (int a = 0; a < 5; a++) begin
         if_req = 1'b1; if_addr = 32'(a);
         at_neg();
         chk1("fetch_if_gnt", if_gnt, 1'b1);
         chk1("fetch_dm_gnt", dm_gnt, 1'b0);
         chk1("fetch_mem_en", mem_en, 1'b1);
         chk1("fetch_mem_we", mem_we, 1'b0);
         chkw("fetch_mem_addr", 32'(mem_addr), 32'(a));
         push_if(init_word(a));
         tick();
      end
      if_req = 1'b0;
      tick();
      at_neg();
      chkw("fetch_rdata_hold", if_rdata, init_word(4));
      tick();

      // SW 100 <- 5555, then LW 100
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'd100; dm_wdata = 32'd5555;
      at_neg();
      chk1("sw_dm_gnt", dm_gnt, 1'b1);
      chk1("sw_mem_en", mem_en, 1'b1);
      chk1("sw_mem_we", mem_we, 1'b1);
      chkw("sw_mem_addr", 32'(mem_addr), 32'd100);
      chkw("sw_mem_wdata", mem_wdata, 32'd5555);
      tick();
      dm_we = 1'b0;
      at_neg();
      chk1("lw_dm_gnt", dm_gnt, 1'b1);
      chk1("lw_mem_we", mem_we, 1'b0);
      push_dm(32'd5555);
      tick();
      dm_req = 1'b0;
      tick();
      chkw("sw_ram_word", ram[100], 32'd5555);

      // Contention: DM x4 then IF, repeating
      if_req = 1'b1; if_addr = 32'd5;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd100;
      for (int k = 0; k < 12; k++) begin
         at_neg();
         exp_if = ((k % 5) == 4);
         chk1("cont_if_gnt", if_gnt, exp_if);
         chk1("cont_dm_gnt", dm_gnt, !exp_if);
         if (exp_if) push_if(init_word(5));
         else        push_dm(32'd5555);
         tick();
      end
      if_req = 1'b0; dm_req = 1'b0;
      tick();

      // Out-of-range load
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0400;
      at_neg();
      chk1("oob_dm_gnt", dm_gnt, 1'b1);
      chk1("oob_mem_en", mem_en, 1'b0);
      chk1("oob_err_before", err_oob, 1'b0);
      push_dm(32'd0);
      tick();
      dm_req = 1'b0;
      at_neg();
      chk1("oob_err_set", err_oob, 1'b1);
      tick(); tick();
      at_neg();
      chk1("oob_err_sticky", err_oob, 1'b1);
      tick();

      // Async reset between a load grant and its return
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd100;
      at_neg();
      chk1("pre_lw_gnt", dm_gnt, 1'b1);
      push_dm(32'd5555);
      tick();
      at_neg();
      chk1("ar_lw_gnt", dm_gnt, 1'b1);
      tick();
      rst_n = 1'b0; if_req = 1'b1;
      #1;
      chk1("ar_dm_rvalid", dm_rvalid, 1'b0);
      chk1("ar_if_gnt", if_gnt, 1'b0);
      chk1("ar_dm_gnt", dm_gnt, 1'b0);
      chk1("ar_mem_en", mem_en, 1'b0);
      chkw("ar_mem_addr", 32'(mem_addr), 32'd0);
      chkw("ar_dm_rdata", dm_rdata, 32'd0);
      chk1("ar_err_oob", err_oob, 1'b0);
      tick();
      rst_n = 1'b1; if_req = 1'b0;
      at_neg();
      chk1("ar_resume_gnt", dm_gnt, 1'b1);
      push_dm(32'd5555);
      tick();
      dm_req = 1'b0;
      tick();

      // Halt with a load granted and a store still pending
      halt = 1'b1; if_req = 1'b1; if_addr = 32'd0;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd100;
      at_neg();
      chk1("halt_a_if_gnt", if_gnt, 1'b0);
      chk1("halt_a_dm_gnt", dm_gnt, 1'b1);
      push_dm(32'd5555);
      tick();
      dm_we = 1'b1; dm_addr = 32'd101; dm_wdata = 32'h0000_A5A5;
      at_neg();
      chkw("halt_b_state", 32'(dbg_state), 32'(DRAIN));
      chk1("halt_b_if_gnt", if_gnt, 1'b0);
      chk1("halt_b_dm_gnt", dm_gnt, 1'b1);
      chk1("halt_b_mem_we", mem_we, 1'b1);
      chk1("halt_b_halted", halted, 1'b0);
      tick();
      dm_req = 1'b0;
      at_neg();
      chk1("halt_c_if_gnt", if_gnt, 1'b0);
      chk1("halt_c_mem_en", mem_en, 1'b0);
      chk1("halt_c_halted", halted, 1'b0);
      tick();
      dm_req = 1'b1; dm_we = 1'b0;
      at_neg();
      chk1("halt_d_halted", halted, 1'b1);
      chkw("halt_d_state", 32'(dbg_state), 32'(HALTED));
      chk1("halt_d_if_gnt", if_gnt, 1'b0);
      chk1("halt_d_dm_gnt", dm_gnt, 1'b0);
      chk1("halt_d_mem_en", mem_en, 1'b0);
      chkw("halt_sw_ram_word", ram[101], 32'h0000_A5A5);
      tick(); tick();
      at_neg();
      chk1("halt_stays", halted, 1'b1);
      chk1("halt_mem_en_off", mem_en, 1'b0);
      tick();

      // Reset is the only way out of HALTED
      dm_req = 1'b0; halt = 1'b0; rst_n = 1'b0;
      #1;
      chk1("rr_halted", halted, 1'b0);
      tick();
      rst_n = 1'b1; if_addr = 32'd1;
      at_neg();
      chk1("rr_if_gnt", if_gnt, 1'b1);
      push_if(init_word(1));
      tick();
      if_req = 1'b0;
      tick(); tick();

      chkw("if_q_drained", 32'(if_exp_q.size()), 32'd0);
      chkw("dm_q_drained", 32'(dm_exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
